half_adder_sync: RTL and testbench
==================================

// Module: half_adder_sync
// PURPOSE
//  Vector of WIDTH independent 1-bit half adders with combinational sum/carry outputs.
//  Also provides a registered copy of the results with a valid flag and a saturating
//  counter of carry events. Used as a leaf arithmetic primitive and as a self-checking
//  building block in larger adder datapaths.
// PARAMETERS
//  WIDTH      1   number of independent half-adder lanes (>=1)
//  CNT_W      8   width of carry-event counter (>=1)
// PORTS
//  clk        in   1        rising-edge clock; single clock domain
//  rst        in   1        synchronous, active-high reset
//  a          in   WIDTH    operand A, one bit per lane
//  b          in   WIDTH    operand B, one bit per lane
//  in_valid   in   1        qualifies a/b for the registered stage and counter
//  sum        out  WIDTH    combinational a ^ b, per lane
//  carry      out  WIDTH    combinational a & b, per lane
//  sum_q      out  WIDTH    registered sum
//  carry_q    out  WIDTH    registered carry
//  out_valid  out  1        registered in_valid
//  carry_cnt  out  CNT_W    count of accepted cycles with any carry lane set
//  cnt_sat    out  1        high while carry_cnt is at all-ones
// BEHAVIOUR
//  - Combinational path: sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i]. No clock/reset
//    dependence and no gating by in_valid; settles in the same delta as the input change.
//  - Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
//  - Sum + carry identity: {carry[i],sum[i]} == a[i] + b[i] (2-bit result).
//  - Registered path, latency 1 cycle: on a rising clk edge with in_valid=1, sum_q<=sum,
//    carry_q<=carry. With in_valid=0, sum_q/carry_q hold their values.
//  - out_valid <= in_valid on every clock edge (single-cycle pulse per accepted input).
//  - carry_cnt increments by 1 on an edge where in_valid=1 and |carry=1. It saturates at
//    2**CNT_W-1 and never wraps; cnt_sat = &carry_cnt.
//  - Reset (rst=1 at a rising edge) takes priority over everything. It clears sum_q,
//    carry_q, out_valid, and carry_cnt to 0 and cnt_sat to 0. Combinational outputs are
//    unaffected by reset.
//  - Reset mid-operation: a pending in_valid in the reset cycle is dropped, so out_valid=0
//    on the next cycle.
//  - No handshake backpressure: every in_valid cycle is accepted.
//  - Width rule: all lanes are independent; there is no carry propagation between lanes.
// TESTING
//  1. WIDTH=1: apply a,b = 00,01,10,11 at 10-unit steps -> sum,carry = 00,10,10,01 with
//     no clock edge required.
//  2. Apply the same sequence with in_valid=1 each cycle -> sum_q/carry_q match the
//     previous cycle's sum/carry; out_valid is high from cycle 2.
//  3. Hold a=b=1, in_valid=1 for 300 cycles with CNT_W=8 -> carry_cnt=255, cnt_sat=1,
//     and no wrap.
//  4. Assert rst with a=b=1 and in_valid=1 -> next cycle sum_q=carry_q=out_valid=0 and
//     carry_cnt=0, while combinational carry=1 throughout.
//  5. WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000; with in_valid=1,
//     carry_cnt increments by 1.
//  6. in_valid=0 with changing a/b -> sum/carry track the inputs; sum_q, carry_q and
//     carry_cnt hold.

Source files
------------

// File: rtl/half_adder_sync.sv
// Lane-parallel half adders: combinational sum/carry per lane, plus a registered
// copy with valid flag and a saturating counter of cycles that produced any carry.

module half_adder_lane (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module half_adder_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  // Lanes are fully independent; nothing ripples between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  logic [WIDTH-1:0] sum_d, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic             cnt_full;

  assign cnt_full = &carry_cnt_q;

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    carry_cnt_d = carry_cnt_q;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
      // Saturate rather than wrap so a long carry burst never reads as small.
      if (|carry && !cnt_full)
        carry_cnt_d = carry_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign carry_cnt = carry_cnt_q;
  assign cnt_sat   = cnt_full;

endmodule

// File: tb/tb_half_adder_sync.sv
module tb_half_adder_sync;

  logic clk = 1'b0;
  logic rst;

  logic       a1, b1, iv1;
  logic       sum1, carry1, sum_q1, carry_q1, ov1, sat1;
  logic [7:0] cnt1;

  logic [3:0] a4, b4;
  logic       iv4;
  logic [3:0] sum4, carry4, sum_q4, carry_q4;
  logic       ov4, sat4;
  logic [7:0] cnt4;

  int checks = 0;
  int errors = 0;

  logic vec_a [4];
  logic vec_b [4];
  logic exp_s [4];
  logic exp_c [4];

  always #5 clk = ~clk;

  half_adder_sync #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
    .out_valid(ov1), .carry_cnt(cnt1), .cnt_sat(sat1)
  );

  half_adder_sync #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
    .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4),
    .out_valid(ov4), .carry_cnt(cnt4), .cnt_sat(sat4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_a = '{1'b0, 1'b0, 1'b1, 1'b1};
    vec_b = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; iv4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum_q", sum_q1, 1'b0);
    chk("rst_carry_q", carry_q1, 1'b0);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_cnt", cnt1, 8'd0);
    chk("rst_sat", sat1, 1'b0);
    chk("rst_cnt4", cnt4, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = vec_a[i]; b1 = vec_b[i];
      #1;
      chk("comb_sum", sum1, exp_s[i]);
      chk("comb_carry", carry1, exp_c[i]);
    end
    @(negedge clk);
    chk("idle_sum_q", sum_q1, 1'b0);
    chk("idle_carry_q", carry_q1, 1'b0);
    chk("idle_out_valid", ov1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      a1 = vec_a[i]; b1 = vec_b[i]; iv1 = 1'b1;
      @(negedge clk);
      chk("reg_sum_q", sum_q1, exp_s[i]);
      chk("reg_carry_q", carry_q1, exp_c[i]);
      chk("reg_out_valid", ov1, 1'b1);
    end
    chk("reg_cnt", cnt1, 8'd1);

    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("hold_comb_sum", sum1, 1'b1);
    chk("hold_comb_carry", carry1, 1'b0);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("hold_out_valid", ov1, 1'b0);
    chk("hold_sum_q", sum_q1, 1'b0);
    chk("hold_carry_q", carry_q1, 1'b1);
    chk("hold_cnt", cnt1, 8'd1);

    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 253) begin
        chk("sat_pre_cnt", cnt1, 8'd254);
        chk("sat_pre_flag", sat1, 1'b0);
      end
    end
    chk("sat_cnt", cnt1, 8'd255);
    chk("sat_flag", sat1, 1'b1);

    rst = 1'b1;
    #1;
    chk("rst_comb_carry", carry1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_sum_q", sum_q1, 1'b0);
    chk("mid_rst_carry_q", carry_q1, 1'b0);
    chk("mid_rst_out_valid", ov1, 1'b0);
    chk("mid_rst_cnt", cnt1, 8'd0);
    chk("mid_rst_sat", sat1, 1'b0);
    chk("mid_rst_comb_carry", carry1, 1'b1);
    @(negedge clk);
    iv1 = 1'b0;
    chk("post_rst_out_valid", ov1, 1'b1);
    chk("post_rst_cnt", cnt1, 8'd1);

    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
    #1;
    chk("w4_sum", sum4, 4'b0110);
    chk("w4_carry", carry4, 4'b1000);
    @(negedge clk);
    chk("w4_sum_q", sum_q4, 4'b0110);
    chk("w4_carry_q", carry_q4, 4'b1000);
    chk("w4_cnt", cnt4, 8'd1);
    chk("w4_out_valid", ov4, 1'b1);

    a4 = 4'b1111; b4 = 4'b0001;
    #1;
    chk("w4_nprop_sum", sum4, 4'b1110);
    chk("w4_nprop_carry", carry4, 4'b0001);

    a4 = 4'b0101; b4 = 4'b1010;
    @(negedge clk);
    chk("w4_nocarry_sum_q", sum_q4, 4'b1111);
    chk("w4_nocarry_carry_q", carry_q4, 4'b0000);
    chk("w4_nocarry_cnt", cnt4, 8'd1);

    iv4 = 1'b0; a4 = 4'b0011; b4 = 4'b0101;
    #1;
    chk("w4_idle_sum", sum4, 4'b0110);
    chk("w4_idle_carry", carry4, 4'b0001);
    @(negedge clk);
    chk("w4_idle_sum_q", sum_q4, 4'b1111);
    chk("w4_idle_carry_q", carry_q4, 4'b0000);
    chk("w4_idle_cnt", cnt4, 8'd1);
    chk("w4_idle_out_valid", ov4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
